// File: rtl/uart_pkg.sv
// Shared UART constants and state encodings, used by both the receiver and the transmitter.
// Helper functions derive the bit-period and mid-bit sample constants from any clock/baud pair.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 9600;

  function automatic int unsigned calc_baud_cnt_max(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned calc_sample_pt(input int unsigned baud_cnt_max);
    return baud_cnt_max / 2 - 1;
  endfunction

  localparam int unsigned BAUD_CNT_MAX = calc_baud_cnt_max(DEF_CLK_FREQ, DEF_BAUD_RATE);
  localparam int unsigned SAMPLE_PT    = calc_sample_pt(BAUD_CNT_MAX);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer plus delay flop for the serial line.
// Produces a one-cycle falling-edge strobe for start-bit detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s,
  output logic fall
);

  logic       meta_q;
  logic       sync_q;
  logic       dly_q;
  logic [1:0] vld_q;
  logic       armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      dly_q   <= 1'b1;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      vld_q  <= {vld_q[0], 1'b1};
      // Arm only after a real (not reset-preset) high is seen, so a line held low
      // across reset release cannot fake a start edge.
      if (vld_q[1] && sync_q) armed_q <= 1'b1;
    end
  end

  assign rx_s = sync_q;
  assign fall = armed_q & ~sync_q & dly_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, one-cycle po_flag / frame_err pulses.
// Returns to IDLE at the stop-bit sample so back-to-back frames are accepted.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);

  localparam int unsigned CNT_MAX = calc_baud_cnt_max(CLK_FREQ, BAUD_RATE);
  localparam int unsigned SMP_PT  = calc_sample_pt(CNT_MAX);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic             rx_s;
  logic             fall;
  logic             strobe;
  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             flag_q, flag_d;
  logic             err_q, err_d;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_i  (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign strobe = (baud_cnt_q == CNT_W'(SMP_PT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      flag_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      flag_q     <= flag_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    flag_d     = 1'b0;
    err_d      = 1'b0;

    if (state_q != ST_IDLE) begin
      baud_cnt_d = (baud_cnt_q == CNT_W'(CNT_MAX - 1)) ? '0 : baud_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (strobe) begin
          if (rx_s) begin
            state_d    = ST_IDLE;
            baud_cnt_d = '0;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (strobe) begin
          shift_d[bit_cnt_q] = rx_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (strobe) begin
          if (rx_s) begin
            data_d = shift_q;
            flag_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d    = ST_IDLE;
          baud_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  assign po_data   = data_q;
  assign po_flag   = flag_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected pulses, a negedge monitor pops and checks them.
// Uses a short bit period (32 clocks) so the whole run stays small.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 3_200_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int unsigned B         = CLK_FREQ / BAUD_RATE;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;

  exp_t       exp_q[$];
  int         flag_t[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] model_data = 8'h00;
  logic       prev_flag = 1'b0;
  logic       prev_err = 1'b0;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard; po_data must otherwise hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_flag = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (po_flag || frame_err) begin
        check("flag_err_exclusive", 32'(po_flag & frame_err), 32'd0);
        check("pulse_width", 32'((po_flag & prev_flag) | (frame_err & prev_err)), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: po_flag=%0b frame_err=%0b po_data=%02h, expected no pulse",
                   po_flag, frame_err, po_data);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
          if (!e.is_err) model_data = e.data;
          check("po_data_at_pulse", 32'(po_data), 32'(model_data));
          if (po_flag) flag_t.push_back(cyc);
        end
      end else begin
        check("po_data_stable", 32'(po_data), 32'(model_data));
      end
      prev_flag = po_flag;
      prev_err  = frame_err;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(B);
    end
    rx = stop_bit;
    tick(B);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back('{1'b0, b});
    send_frame(b, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4 * B && exp_q.size() != 0; i++) tick(1);
    check({"drain_", name}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    check("reset_po_data", 32'(po_data), 32'h00);
    check("reset_po_flag", 32'(po_flag), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Single byte 0x55
    send_byte(8'h55);
    tick(B);
    drain("55");
    check("rx_55", 32'(po_data), 32'h55);

    // Short low glitch: must not produce any output
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(3 * B);
    check("glitch_po_data", 32'(po_data), 32'h55);

    // Good byte, then framing error
    send_byte(8'hA3);
    tick(B);
    drain("A3");
    check("rx_A3", 32'(po_data), 32'hA3);
    exp_q.push_back('{1'b1, 8'h00});
    send_frame(8'hF0, 1'b0);
    rx = 1'b1;
    tick(2 * B);
    drain("ferr");
    check("ferr_keeps_data", 32'(po_data), 32'hA3);

    // Back-to-back frames, no idle gap
    flag_t.delete();
    send_byte(8'h3C);
    send_byte(8'hC3);
    tick(B);
    drain("b2b");
    check("b2b_count", 32'(flag_t.size()), 32'd2);
    if (flag_t.size() == 2) check("b2b_spacing", 32'(flag_t[1] - flag_t[0]), 32'(10 * B));
    check("b2b_last", 32'(po_data), 32'hC3);

    // Reset in the middle of an 0xFF frame
    rx = 1'b0;
    tick(B);
    rx = 1'b1;
    tick(3 * B);
    rst_n = 1'b0;
    model_data = 8'h00;
    #1;
    check("midreset_po_data", 32'(po_data), 32'h00);
    check("midreset_po_flag", 32'(po_flag), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(8 * B);
    check("after_abort_data", 32'(po_data), 32'h00);
    send_byte(8'h12);
    tick(B);
    drain("12");
    check("rx_12", 32'(po_data), 32'h12);

    // Line held low across reset release
    rx = 1'b0;
    rst_n = 1'b0;
    model_data = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(2 * B);
    check("low_release_data", 32'(po_data), 32'h00);
    rx = 1'b1;
    tick(B);
    flag_t.delete();
    send_byte(8'h81);
    tick(2 * B);
    drain("81");
    check("low_release_count", 32'(flag_t.size()), 32'd1);
    check("rx_81", 32'(po_data), 32'h81);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial line bit rate.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line; idle high; frame is 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
REQ-006 SHALL have port po_data, output, 8, last correctly received byte; it feeds the transmitter's ip_data.
REQ-007 SHALL have port po_flag, output, 1, single-cycle pulse meaning po_data is newly valid; it feeds the transmitter's ip_flag.
REQ-008 SHALL have port frame_err, output, 1, single-cycle pulse meaning the stop bit was sampled low.

Function
REQ-009 SHALL derive BAUD_CNT_MAX = CLK_FREQ/BAUD_RATE (5208 at defaults) and SAMPLE_PT = BAUD_CNT_MAX/2 - 1 (2603 at defaults).
REQ-010 SHALL pass rx through a 2-flop synchronizer plus one delay flop; a falling edge is synchronized=0 while delayed=1.
REQ-011 SHALL implement states IDLE, START, DATA and STOP as one-hot encoding.
REQ-012 IDLE: baud_cnt is held at 0; a falling edge moves the FSM to START on the next clock, and baud_cnt starts counting from 0.
REQ-013 SHALL count baud_cnt 0..BAUD_CNT_MAX-1 and wrap to 0 in every non-IDLE state; the sample strobe is baud_cnt==SAMPLE_PT.
REQ-014 START: at the strobe, synchronized rx=1 is treated as a glitch and returns the FSM to IDLE with no output; rx=0 moves it to DATA with bit_cnt=0.
REQ-015 DATA: each strobe shifts synchronized rx into shift register bit position bit_cnt (LSB first) and increments bit_cnt; after the 8th strobe the FSM moves to STOP.
REQ-016 STOP: at the strobe, rx=1 loads po_data from the shift register and sets po_flag high for exactly the next clock.
REQ-017 STOP: at the strobe, rx=0 sets frame_err high for exactly the next clock; po_data keeps its previous value and po_flag stays low.
REQ-018 SHALL return to IDLE at the stop-bit strobe, without waiting for the end of the stop bit, so a start edge that directly follows the stop bit is accepted.
REQ-019 SHALL have latency from the START-entry clock to po_flag high of 9*BAUD_CNT_MAX + SAMPLE_PT + 2 clocks.
REQ-020 SHALL ignore falling edges on rx outside IDLE.
REQ-021 SHALL hold po_data stable between po_flag pulses; po_flag and frame_err never assert in the same cycle.

Reset
REQ-022 On rst_n low, SHALL asynchronously reset: FSM=IDLE, baud_cnt=0, bit_cnt=0, shift register=0, po_data=8'h00, po_flag=0, frame_err=0, and all synchronizer/delay flops=1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no po_flag or frame_err pulse.
REQ-024 rx held low across reset release SHALL NOT start a frame; a high-to-low transition is required first.

Structure
REQ-025 CLK_FREQ, BAUD_RATE defaults, derived BAUD_CNT_MAX and SAMPLE_PT, and the state encodings SHALL live in shared package uart_pkg, which the transmitter also uses.
REQ-026 The synchronizer plus edge detector SHALL be sub-module uart_rx_sync, with outputs rx_s and fall; everything else is flat.

Verification
REQ-027 Byte 8'h55 sent at 9600 baud -> po_data=8'h55 and one po_flag pulse of width 1 clock; frame_err stays 0.
REQ-028 rx low for 1000 clocks then high (glitch) -> FSM back in IDLE; no po_flag or frame_err; po_data unchanged.
REQ-029 8'hA3 sent, then 8'hF0 with stop bit driven 0 -> first po_flag with po_data=8'hA3; then one frame_err pulse, po_data still 8'hA3.
REQ-030 8'h3C and 8'hC3 back-to-back with no idle gap -> two po_flag pulses 10*5208 clocks apart, data 8'h3C then 8'hC3.
REQ-031 rst_n pulsed low mid-DATA of 8'hFF -> all outputs 0 immediately; no pulse for the aborted frame; next 8'h12 is received correctly.
REQ-032 rx held 0 through reset release, then raised to 1, then 8'h81 sent -> exactly one po_flag with po_data=8'h81.
